// File: rtl/code_mem_loader.sv
// code_mem_loader: parametrised instruction store with sequential clear,
// streamed append and registered, length-masked fetch.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   clear_code       level; starts or restarts a DEPTH-cycle clear
//   getcode          append instruction_in this cycle
//   instruction_in   word to append
//   fetch_en, pc     fetch request and address
//   instruction_out  registered fetch data (1-cycle latency)
//   code_len         number of loaded words, 0..DEPTH
//   busy             high while clearing
//   full             code_len == DEPTH
//   load_err         sticky; an appended word was dropped
module code_mem_loader #(
  parameter int unsigned         INSTR_W   = 16,
  parameter int unsigned         DEPTH     = 64,
  parameter int unsigned         ADDR_W    = 6,
  parameter logic [INSTR_W-1:0]  FILL_WORD = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_code,
  input  logic               getcode,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W:0]    code_len,
  output logic               busy,
  output logic               full,
  output logic               load_err
);

  localparam int unsigned       LEN_W    = ADDR_W + 1;
  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0]  DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic [LEN_W-1:0]     code_len_q, code_len_d;
  logic                 load_err_q, load_err_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;

  logic                 mem_we_c;
  logic [IDX_W-1:0]     mem_waddr_c;
  logic [INSTR_W-1:0]   mem_wdata_c;
  logic [INSTR_W-1:0]   mem_q [DEPTH];

  // State and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      code_len_q <= '0;
      load_err_q <= 1'b0;
      instr_q    <= FILL_WORD;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      code_len_q <= code_len_d;
      load_err_q <= load_err_d;
      instr_q    <= instr_d;
    end
  end

  // Storage array; not reset, code_len masks stale contents
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  // Next-state, write port and fetch logic
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    code_len_d  = code_len_q;
    load_err_d  = load_err_q;
    instr_d     = instr_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = FILL_WORD;

    // Fetch compares against the pre-append length: no write-through.
    // pc >= DEPTH is always >= code_len, so it is masked too.
    if (state_q == CLEAR) begin
      instr_d = FILL_WORD;
    end else if (fetch_en) begin
      if (LEN_W'(pc) < code_len_q) instr_d = mem_q[IDX_W'(pc)];
      else                         instr_d = FILL_WORD;
    end

    case (state_q)
      IDLE: begin
        if (clear_code) begin
          // Clear wins over a same-cycle append and wipes the error flag
          state_d    = CLEAR;
          code_len_d = '0;
          clr_ptr_d  = '0;
          load_err_d = 1'b0;
        end else if (getcode) begin
          if (code_len_q < DEPTH_L) begin
            mem_we_c    = 1'b1;
            mem_waddr_c = IDX_W'(code_len_q);
            mem_wdata_c = instruction_in;
            code_len_d  = code_len_q + LEN_W'(1);
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = IDX_W'(clr_ptr_q);
        if (clear_code) begin
          // Restart: DEPTH more cycles counted from this assertion
          clr_ptr_d  = '0;
          load_err_d = 1'b0;
        end else begin
          if (getcode) load_err_d = 1'b1;
          if (clr_ptr_q == LAST_PTR) state_d = IDLE;
          else                       clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instruction_out = instr_q;
  assign code_len        = code_len_q;
  assign busy            = (state_q == CLEAR);
  assign full            = (code_len_q == DEPTH_L);
  assign load_err        = load_err_q;

endmodule

// File: tb/tb_code_mem_loader.sv
// Bench for code_mem_loader: a DEPTH=64 and a DEPTH=4 instance share the
// same stimulus and are checked every cycle against a queue/count model.
module tb_code_mem_loader;

  logic        clk;
  logic        reset_n;
  logic        clear_code;
  logic        getcode;
  logic [15:0] instruction_in;
  logic        fetch_en;
  logic [5:0]  pc;

  logic [15:0] out64, out4;
  logic [6:0]  len64, len4;
  logic        busy64, busy4, full64, full4, err64, err4;

  int n_vec = 0;
  int n_err = 0;

  code_mem_loader u64 (
    .clk(clk), .reset_n(reset_n), .clear_code(clear_code), .getcode(getcode),
    .instruction_in(instruction_in), .fetch_en(fetch_en), .pc(pc),
    .instruction_out(out64), .code_len(len64), .busy(busy64), .full(full64),
    .load_err(err64)
  );

  code_mem_loader #(.DEPTH(4)) u4 (
    .clk(clk), .reset_n(reset_n), .clear_code(clear_code), .getcode(getcode),
    .instruction_in(instruction_in), .fetch_en(fetch_en), .pc(pc),
    .instruction_out(out4), .code_len(len4), .busy(busy4), .full(full4),
    .load_err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of loaded words, remaining busy cycles, error flag
  logic [15:0] mw   [2][64];
  int          mlen [2];
  int          mcnt [2];
  logic        merr [2];
  logic [15:0] mout [2];
  int          mdep [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mlen[k] = 0; mcnt[k] = 0; merr[k] = 1'b0; mout[k] = 16'h0000;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit bz;
      bz = (mcnt[k] != 0);
      if (bz) mout[k] = 16'h0000;
      else if (fetch_en) mout[k] = (int'(pc) < mlen[k]) ? mw[k][pc] : 16'h0000;
      if (clear_code) begin
        mlen[k] = 0; merr[k] = 1'b0; mcnt[k] = mdep[k];
      end else if (bz) begin
        if (getcode) merr[k] = 1'b1;
        mcnt[k]--;
      end else if (getcode) begin
        if (mlen[k] < mdep[k]) begin
          mw[k][mlen[k]] = instruction_in;
          mlen[k]++;
        end else begin
          merr[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out64",  32'(out64),  32'(mout[0]));
    check("len64",  32'(len64),  32'(mlen[0]));
    check("busy64", 32'(busy64), 32'(mcnt[0] != 0));
    check("full64", 32'(full64), 32'(mlen[0] == mdep[0]));
    check("err64",  32'(err64),  32'(merr[0]));
    check("out4",   32'(out4),   32'(mout[1]));
    check("len4",   32'(len4),   32'(mlen[1]));
    check("busy4",  32'(busy4),  32'(mcnt[1] != 0));
    check("full4",  32'(full4),  32'(mlen[1] == mdep[1]));
    check("err4",   32'(err4),   32'(merr[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic c, input logic g, input logic [15:0] d,
                       input logic f, input logic [5:0] p);
    clear_code = c; getcode = g; instruction_in = d; fetch_en = f; pc = p;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Counts busy cycles of the 64-deep instance, starting from the current sample
  task automatic count_busy(output int n);
    n = 0;
    while (busy64 && n < 300) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic        clr;
    logic        gc;
    logic [15:0] din;
    logic        fe;
    logic [5:0]  pc;
    logic [15:0] eout;
    logic [6:0]  elen;
  } vec_t;

  vec_t tbl [10];
  int   n;

  initial begin
    mdep[0] = 64; mdep[1] = 4;
    tbl[0] = '{1'b0, 1'b1, 16'h8000, 1'b0, 6'd0, 16'h0000, 7'd1};
    tbl[1] = '{1'b0, 1'b1, 16'h8400, 1'b0, 6'd0, 16'h0000, 7'd2};
    tbl[2] = '{1'b0, 1'b1, 16'hA000, 1'b1, 6'd2, 16'h0000, 7'd3};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'd0, 16'h8000, 7'd3};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'd1, 16'h8400, 7'd3};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'd2, 16'hA000, 7'd3};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'd3, 16'h0000, 7'd3};
    tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0000, 7'd3};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 6'd1, 16'h8400, 7'd3};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 6'd2, 16'h8400, 7'd3};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // One-cycle clear pulse: busy for exactly 64 cycles, then table load/fetch
    drive(1'b1, 1'b0, 16'h0, 1'b0, 6'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
    count_busy(n);
    check("clear_busy_cycles", 32'(n), 32'd64);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].clr, tbl[i].gc, tbl[i].din, tbl[i].fe, tbl[i].pc);
      tick();
      check($sformatf("tbl%0d_out", i), 32'(out64), 32'(tbl[i].eout));
      check($sformatf("tbl%0d_len", i), 32'(len64), 32'(tbl[i].elen));
    end

    // Reset mid-stream after three words
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 16'h5550 + 16'(i), 1'b1, 6'(i));
      tick();
    end
    drive(1'b0, 1'b1, 16'h5553, 1'b1, 6'd0);
    do_reset();
    check("rst_len", 32'(len64), 32'd0);
    check("rst_out", 32'(out64), 32'h0000);
    check("rst_err", 32'(err64), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 6'd0);
    tick();
    check("rst_fetch0", 32'(out64), 32'h0000);

    // Overfill the 4-deep instance
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 1'b1, 16'(i), 1'b0, 6'd0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 6'd3);
    tick();
    check("d4_len", 32'(len4), 32'd4);
    check("d4_full", 32'(full4), 32'd1);
    check("d4_err", 32'(err4), 32'd1);
    check("d4_fetch3", 32'(out4), 32'h0004);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 6'd5);
    tick();
    check("d4_fetch_oob", 32'(out4), 32'h0000);

    // Append during clear is dropped; clear+append same cycle leaves no error
    drive(1'b1, 1'b0, 16'h0, 1'b0, 6'd0);
    tick();
    drive(1'b0, 1'b1, 16'h1234, 1'b0, 6'd0);
    tick();
    check("busy_drop_err", 32'(err64), 32'd1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
    count_busy(n);
    check("busy_drop_len", 32'(len64), 32'd0);
    check("busy_drop_err_after", 32'(err64), 32'd1);
    drive(1'b1, 1'b1, 16'h4321, 1'b0, 6'd0);
    tick();
    check("clr_gc_len", 32'(len64), 32'd0);
    check("clr_gc_err", 32'(err64), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 6'd0);
    count_busy(n);

    // Re-assert clear at cycle 10; fetch during busy returns fill
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 6'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 6'd0);
    tick();
    check("pre_clear_out", 32'(out64), 32'hBEEF);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 6'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 6'd0);
    repeat (9) tick();
    drive(1'b1, 1'b0, 16'h0, 1'b1, 6'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 6'd0);
    check("busy_fetch_out", 32'(out64), 32'h0000);
    count_busy(n);
    check("restart_busy_cycles", 32'(n), 32'd64);

    // Two bursts separated by idle cycles stay contiguous
    drive(1'b0, 1'b1, 16'h1111, 1'b0, 6'd0); tick();
    drive(1'b0, 1'b1, 16'h2222, 1'b0, 6'd0); tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 6'd0);    repeat (3) tick();
    drive(1'b0, 1'b1, 16'h3333, 1'b0, 6'd0); tick();
    drive(1'b0, 1'b1, 16'h4444, 1'b0, 6'd0); tick();
    check("burst_len", 32'(len64), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b1, 6'(i));
      tick();
      check($sformatf("burst_fetch%0d", i), 32'(out64), 32'(16'h1111 * 16'(i + 1)));
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 6'd1);
    repeat (2) tick();
    check("hold_out", 32'(out64), 32'h4444);

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
